keypad_scan4x4: RTL and testbench
=================================

Name: keypad_scan4x4

Overview:
- Input-side counterpart of the multiplexed 7-segment output path.
- The display path scans anodes out and drives segments; this block scans keypad columns out and senses rows in.
- Drives a 4x4 matrix keypad one column at a time, samples the rows and rejects ghost (multi-key) frames.
- Debounces over whole scan frames, then delivers a 4-bit key code with a one-cycle valid strobe to the vending-machine control logic.

Parameters:
- SCAN_DIV, 50000, clk cycles each column is driven; must be >= 4.
- DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames needed to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- row  input  4  keypad rows, active-low (pulled up externally); asynchronous to clk
- col  output  4  keypad column drive, active-low, exactly one bit low at all times
- key_code  output  4  accepted key, code = row_idx*4 + col_idx
- key_valid  output  1  one-cycle pulse when a new press is accepted
- key_held  output  1  high from acceptance until release is accepted

Behaviour:
- Reset (rst_n low at a clk edge, any time, including mid-scan or mid-debounce):
  - col=4'b1110; key_code=0; key_valid=0; key_held=0.
  - Divider, column index, frame accumulators and debounce counter all 0; state IDLE.
  - Synchronizer flops preset to 4'b1111.
- Row synchronizer: 2-flop on all 4 row bits; raw row is never used directly.
- Divider: counts 0..SCAN_DIV-1.
  - Terminal count (TC) occurs at SCAN_DIV-1.
  - At TC, the synchronized row is sampled for the current column. In the same edge, the column index advances 0->1->2->3->0 and col updates.
  - col pattern by index: 1110, 1101, 1011, 0111. Frame length = 4*SCAN_DIV cycles.
- Frame accumulation:
  - Per sample, count the low bits of the synchronized row and record the row/col index of a low bit.
  - Frame result at the column-3 TC:
    - NONE: 0 low bits in the frame.
    - KEY(code): exactly 1 low bit in the frame.
    - MULTI: 2 or more low bits (ghost rejection; never accepted).
  - Accumulators clear for the next frame in the same edge.
- Debounce FSM, evaluated only at the column-3 TC:
  - IDLE: result KEY(c) -> DEBOUNCE, cand=c, cnt=1. If DEBOUNCE_FRAMES=1, go directly to accept.
  - DEBOUNCE: result KEY(cand) -> cnt+1. Anything else -> IDLE, cnt=0. When cnt reaches DEBOUNCE_FRAMES -> accept.
  - Accept: key_code<=cand, key_held<=1, key_valid high for exactly the next clk cycle, state PRESSED, cnt=0.
  - PRESSED: result NONE -> cnt+1; KEY or MULTI -> cnt=0. Other keys are ignored while held. When cnt reaches DEBOUNCE_FRAMES -> key_held<=0, state IDLE.
  - key_code holds its last accepted value after release; it changes only on accept or reset.
- Latency: key_valid asserts in the cycle following the column-3 TC of the DEBOUNCE_FRAMES-th consecutive matching frame.
- key_valid is never high for 2 consecutive cycles. At most one pulse per press, regardless of hold time.
- Widths: divider ceil(log2(SCAN_DIV)) bits; debounce counter ceil(log2(DEBOUNCE_FRAMES+1)) bits; counters saturate at their terminal values, never wrap.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=3 (frame = 16 cycles). The bench keypad model pulls row[r] low while col[c] is low and key (r,c) is pressed.
1. rst_n low 5 cycles, no keys -> col=1110, key_valid=0, key_held=0, key_code=0; after release col steps 1110,1101,1011,0111 every 4 cycles; key_valid never pulses.
2. Press (r=2,c=1) steady for 20 frames -> exactly one key_valid pulse, after the 3rd full matching frame; key_code=9 and key_held=1 from that cycle on.
3. Toggle (r=1,c=3) every 5 cycles for 2 frames, then hold -> no pulse during bounce; one pulse with key_code=7 after 3 steady frames.
4. Hold (0,0) and (3,3) together for 10 frames -> key_valid never pulses, key_held stays 0.
5. After scenario 2, release for 1 frame, re-press for 2 frames -> key_held stays 1, no new pulse. Then release 3 frames -> key_held=0, key_code stays 9. Re-press (0,2) -> pulse with key_code=2.
6. Reset asserted while key_held=1 with the key still pressed -> next cycle all outputs 0 and col=1110; after release a new pulse with the same code follows 3 full frames later.

Source files
------------

// File: rtl/keypad_scan4x4.sv
// keypad_scan4x4 -- 4x4 matrix keypad scanner with frame-level debounce.
// Drives one keypad column low at a time and samples the (synchronized) rows
// at the end of each column slot. A full scan of the four columns forms one
// frame, which is classified as no key, exactly one key, or several keys.
// Several keys in one frame are ghost-prone and are never accepted. A single
// key must be seen for DEBOUNCE_FRAMES consecutive frames before it is
// accepted. A release is accepted after the same number of empty frames.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active-low
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, active-low, exactly one bit low
//   key_code   last accepted key, row_idx*4 + col_idx
//   key_valid  one-cycle pulse when a new press is accepted
//   key_held   high from acceptance until release is accepted
module keypad_scan4x4 #(
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DIV_TC = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  state_t        state, state_nxt;
  logic [3:0]    sync1, sync2;
  logic [DW-1:0] div;
  logic [1:0]    col_idx;
  logic          tc, frame_end;

  // Frame accumulator: low-bit count saturates at 2 (means "several").
  logic [1:0]    acc_cnt, acc_cnt_nxt;
  logic [3:0]    acc_code, acc_code_nxt;
  logic [2:0]    samp_low, tot;
  logic [1:0]    samp_row;
  logic          f_none, f_key;

  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]    cand, cand_nxt, code_nxt;
  logic          held_nxt, valid_nxt, accept;

  assign tc        = (div == DIV_TC);
  assign frame_end = tc && (col_idx == 2'd3);

  always_comb begin
    col = 4'b1111;
    col[col_idx] = 1'b0;
  end

  // Current column sample merged into the running frame result.
  always_comb begin
    samp_low = '0;
    samp_row = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!sync2[r]) begin
        samp_low = samp_low + 3'd1;
        samp_row = 2'(r);
      end
    end
    tot          = {1'b0, acc_cnt} + samp_low;
    acc_cnt_nxt  = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    // If the frame ends with exactly one low bit, only one sample ever
    // contributed, so the last single-bit sample code is the frame code.
    acc_code_nxt = (samp_low == 3'd1) ? {samp_row, col_idx} : acc_code;
  end

  assign f_none = (acc_cnt_nxt == 2'd0);
  assign f_key  = (acc_cnt_nxt == 2'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= '1;
      sync2    <= '1;
      div      <= '0;
      col_idx  <= '0;
      acc_cnt  <= '0;
      acc_code <= '0;
    end else begin
      sync1 <= row;
      sync2 <= sync1;
      if (tc) begin
        div     <= '0;
        col_idx <= col_idx + 2'd1;
        if (col_idx == 2'd3) begin
          acc_cnt  <= '0;
          acc_code <= '0;
        end else begin
          acc_cnt  <= acc_cnt_nxt;
          acc_code <= acc_code_nxt;
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_held  <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cand      <= cand_nxt;
      key_code  <= code_nxt;
      key_held  <= held_nxt;
      key_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    code_nxt  = key_code;
    held_nxt  = key_held;
    valid_nxt = 1'b0;
    accept    = 1'b0;
    cnt_inc   = (cnt == CNT_TC) ? cnt : cnt + CW'(1);
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (f_key) begin
            cand_nxt  = acc_code_nxt;
            cnt_nxt   = CW'(1);
            state_nxt = DEBOUNCE;
            if (CNT_TC == CW'(1)) accept = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (f_key && (acc_code_nxt == cand)) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_TC) accept = 1'b1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        PRESSED: begin
          if (f_none) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_TC) begin
              held_nxt  = 1'b0;
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
    if (accept) begin
      code_nxt  = cand_nxt;
      held_nxt  = 1'b1;
      valid_nxt = 1'b1;
      state_nxt = PRESSED;
      cnt_nxt   = '0;
    end
  end

endmodule

// File: tb/tb_keypad_scan4x4.sv
// tb_keypad_scan4x4 -- bench for keypad_scan4x4 with SCAN_DIV=4,
// DEBOUNCE_FRAMES=3. A keypad model pulls row[r] low while col[c] is low and
// key (r,c) is pressed. A frame-level model predicts col, key_code,
// key_valid and key_held every cycle; directed scenarios add literal checks.
module tb_keypad_scan4x4;
  localparam int SD = 4;
  localparam int DF = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  always #5 clk = ~clk;

  keypad_scan4x4 #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: time index t counts clocks since reset; row seen by the scanner
  // at an edge is the row present two edges earlier.
  int          t, ci, n, run, quiet;
  logic [3:0]  m_s1, m_s2, used, low_now, fcode, cand;
  logic [15:0] seen;
  logic [3:0]  e_col, e_code;
  logic        e_valid, e_held;
  bit          model_ok = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      t = 0; m_s1 = '0; m_s2 = '0; seen = '0; run = 0; quiet = 0; cand = '0;
      e_col = 4'b1110; e_code = '0; e_valid = 1'b0; e_held = 1'b0;
      model_ok = 1;
    end else begin
      ci = (t / SD) % 4;
      used = m_s2;
      for (int r = 0; r < 4; r++) low_now[r] = keys[r*4+ci];
      m_s2 = m_s1;
      m_s1 = low_now;
      e_valid = 1'b0;
      if (t % SD == SD - 1) begin
        for (int r = 0; r < 4; r++) if (used[r]) seen[r*4+ci] = 1'b1;
        if (ci == 3) begin
          n = $countones(seen);
          fcode = '0;
          for (int k = 0; k < 16; k++) if (seen[k]) fcode = 4'(k);
          seen = '0;
          if (!e_held) begin
            if (run == 0) begin
              if (n == 1) begin cand = fcode; run = 1; end
            end else if (n == 1 && fcode == cand) run++;
            else run = 0;
            if (run == DF) begin
              e_code = cand; e_held = 1'b1; e_valid = 1'b1; run = 0; quiet = 0;
            end
          end else begin
            if (n == 0) quiet++; else quiet = 0;
            if (quiet == DF) begin e_held = 1'b0; quiet = 0; end
          end
        end
      end
      t++;
      e_col = 4'b1111;
      e_col[(t / SD) % 4] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("col", 32'(col), 32'(e_col));
      check("key_code", 32'(key_code), 32'(e_code));
      check("key_valid", 32'(key_valid), 32'(e_valid));
      check("key_held", 32'(key_held), 32'(e_held));
    end
    if (key_valid === 1'b1) pulses++;
  end

  task automatic cyc(input int n_cyc);
    repeat (n_cyc) @(negedge clk);
  endtask

  initial begin
    // 1: reset state and column walk
    cyc(5);
    check("rst_col", 32'(col), 32'h0000000e);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    rst_n = 1'b1;
    cyc(3);  check("walk0", 32'(col), 32'h0000000e);
    cyc(1);  check("walk1", 32'(col), 32'h0000000d);
    cyc(4);  check("walk2", 32'(col), 32'h0000000b);
    cyc(4);  check("walk3", 32'(col), 32'h00000007);
    cyc(4);  check("walk4", 32'(col), 32'h0000000e);
    check("s1_pulses", 32'(pulses), 32'd0);

    // 2: steady press (2,1), pressed right at a frame start
    p0 = pulses;
    keys[9] = 1'b1;
    cyc(47); check("s2_early", 32'(key_valid), 32'd0);
    cyc(1);  check("s2_pulse", 32'(key_valid), 32'd1);
    check("s2_code", 32'(key_code), 32'd9);
    cyc(1);  check("s2_after", 32'(key_valid), 32'd0);
    check("s2_held", 32'(key_held), 32'd1);
    cyc(20*16 - 49);
    check("s2_npulse", 32'(pulses - p0), 32'd1);
    check("s2_held_end", 32'(key_held), 32'd1);

    // 5: short release is not a release; long release is
    p0 = pulses;
    keys = '0;    cyc(16);
    keys[9] = 1'b1; cyc(32);
    check("s5_held", 32'(key_held), 32'd1);
    check("s5_nopulse", 32'(pulses - p0), 32'd0);
    keys = '0;    cyc(64);
    check("s5_release", 32'(key_held), 32'd0);
    check("s5_code_kept", 32'(key_code), 32'd9);
    keys[2] = 1'b1; cyc(64);
    check("s5_repress", 32'(pulses - p0), 32'd1);
    check("s5_code2", 32'(key_code), 32'd2);

    // 3: bouncing (1,3) then steady
    keys = '0; cyc(64);
    check("s3_idle", 32'(key_held), 32'd0);
    p0 = pulses;
    for (int i = 0; i < 32; i++) begin
      if (i % 5 == 0) keys[7] = ~keys[7];
      cyc(1);
    end
    check("s3_bounce", 32'(pulses - p0), 32'd0);
    keys[7] = 1'b1; cyc(80);
    check("s3_pulse", 32'(pulses - p0), 32'd1);
    check("s3_code", 32'(key_code), 32'd7);

    // 4: ghost pair (0,0)+(3,3)
    keys = '0; cyc(64);
    p0 = pulses;
    keys[0] = 1'b1; keys[15] = 1'b1; cyc(160);
    check("s4_pulse", 32'(pulses - p0), 32'd0);
    check("s4_held", 32'(key_held), 32'd0);

    // 6: reset while a key is held
    keys = '0; cyc(64);
    keys[6] = 1'b1; cyc(64);
    check("s6_held", 32'(key_held), 32'd1);
    check("s6_code", 32'(key_code), 32'd6);
    rst_n = 1'b0; cyc(1);
    check("s6_rst_col", 32'(col), 32'h0000000e);
    check("s6_rst_code", 32'(key_code), 32'd0);
    check("s6_rst_valid", 32'(key_valid), 32'd0);
    check("s6_rst_held", 32'(key_held), 32'd0);
    rst_n = 1'b1;
    cyc(47); check("s6_early", 32'(key_valid), 32'd0);
    cyc(1);  check("s6_pulse", 32'(key_valid), 32'd1);
    check("s6_code2", 32'(key_code), 32'd6);
    cyc(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
